btn_debouncer: RTL



---
 rtl/btn_debouncer_pkg.sv | 15 +
 rtl/btn_debouncer_sync_2ff.sv | 27 ++
 rtl/btn_debouncer.sv | 115 +++++++++++
 3 files changed

// File: rtl/btn_debouncer_pkg.sv
// Shared definitions for push-button input conditioning: debounce FSM encoding
// and the default acceptance window.
package btn_debouncer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_PRESS_CHK   = 2'd1,
        ST_HELD        = 2'd2,
        ST_RELEASE_CHK = 2'd3
    } deb_state_t;

    // 1 ms at 50 MHz
    localparam int DEBOUNCE_CYCLES_DEF = 50000;

endpackage

// File: rtl/btn_debouncer_sync_2ff.sv
// Two-flop synchroniser for an asynchronous pin entering the clk domain.
// Both flops reset to RESET_VAL so the output starts at a known idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/btn_debouncer.sv
// Push-button debouncer: polarity normalisation, 2-FF synchroniser and a
// four-state acceptance FSM producing a clean level plus press/release strobes.
module btn_debouncer
    import btn_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release
);

    localparam int                 CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             w_pin_norm;
    logic             w_s;
    deb_state_t       r_state;
    deb_state_t       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_level;
    logic             w_level_nxt;
    logic             r_press;
    logic             w_press_nxt;
    logic             r_release;
    logic             w_release_nxt;

    assign w_pin_norm = ACTIVE_LOW ? ~btn_raw : btn_raw;

    sync_2ff #(
        .RESET_VAL (1'b0)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .i_d   (w_pin_norm),
        .o_q   (w_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_level   <= w_level_nxt;
            r_press   <= w_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Any disagreement of s during a check state drops back and restarts from zero.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_s) begin
                    w_state_nxt = ST_PRESS_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_PRESS_CHK: begin
                if (!w_s) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_HELD: begin
                if (!w_s) begin
                    w_state_nxt = ST_RELEASE_CHK;
                    w_cnt_nxt   = '0;
                end
            end
            ST_RELEASE_CHK: begin
                if (w_s) begin
                    w_state_nxt = ST_HELD;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt   = ST_IDLE;
                    w_cnt_nxt     = '0;
                    w_release_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
        w_level_nxt = (w_state_nxt == ST_HELD) || (w_state_nxt == ST_RELEASE_CHK);
    end

    assign btn_level   = r_level;
    assign btn_press   = r_press;
    assign btn_release = r_release;

endmodule
